reg_access_sequencer: RTL and testbench
=======================================

# reg_access_sequencer

Command-driven initiator that drives the single-port register file (`i_ldSig`/`i_regSel`/`i_regData` in, `o_regData` out) on behalf of the soft-core control path. It accepts one register command at a time over a valid/ready handshake and sequences the read and write cycles needed to complete it. Supported commands: load immediate, register-to-register move, register read-back, and an optional swap. It sits between the instruction decode/control FSM and the register file, so the decoder never toggles the shared select port directly.

## Interface
Parameters:
- `SELECT_WIDTH`, 4: register select width; the file holds 2^SELECT_WIDTH registers.
- `REG_WIDTH`, 8: register data width.

Ports:
- `i_clk`  in  1  system clock; all state changes on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_cmdValid`  in  1  command present.
- `o_cmdReady`  out  1  sequencer can accept a command.
- `i_cmdOp`  in  2  opcode: 00 LOAD_IMM, 01 MOVE, 10 READ, 11 SWAP.
- `i_cmdDst`  in  SELECT_WIDTH  destination register.
- `i_cmdSrc`  in  SELECT_WIDTH  source register.
- `i_cmdImm`  in  REG_WIDTH  immediate for LOAD_IMM.
- `o_ldSig`  out  1  to register file load enable.
- `o_regSel`  out  SELECT_WIDTH  to register file select.
- `o_regData`  out  REG_WIDTH  to register file write data.
- `i_regData`  in  REG_WIDTH  from register file read data (combinational from select).
- `o_rspValid`  out  1  one-cycle pulse; `o_rspData` valid (READ only).
- `o_rspData`  out  REG_WIDTH  read-back value; holds until next READ completes.
- `o_done`  out  1  one-cycle pulse per completed command.
- `o_cmdErr`  out  1  one-cycle pulse, coincident with `o_done`, for an illegal opcode.

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B, FIN.
- IDLE: `o_cmdReady`=1, `o_ldSig`=0. Accept on edge where `i_cmdValid && o_cmdReady`; op/dst/src/imm latched; inputs ignored until back in IDLE.
- LOAD_IMM: IDLE → WR_A (sel=dst, data=imm, ldSig=1) → FIN.
- MOVE: IDLE → RD_A (sel=src, ldSig=0; capture `i_regData` into tmpA at edge) → WR_A (sel=dst, data=tmpA, ldSig=1) → FIN.
- READ: IDLE → RD_A → FIN; `o_rspData`=tmpA, `o_rspValid`=1 in FIN.
- SWAP: IDLE → RD_A (src→tmpA) → RD_B (dst→tmpB) → WR_A (dst←tmpA) → WR_B (src←tmpB) → FIN.
- FIN: `o_done`=1 for one cycle, `o_cmdReady`=0; next state IDLE.
- `o_ldSig` high only in WR_A/WR_B; `o_regSel`/`o_regData` registered per state, 0 in IDLE/FIN.
- src==dst: MOVE and SWAP run the full sequence; register value unchanged.
- No arithmetic; data passes width-unchanged.

## Timing
- Reset (`i_rst` high at edge): state IDLE; next cycle `o_cmdReady`=1, all other outputs 0, tmpA/tmpB/`o_rspData` = 0.
- Reset mid-command aborts at that edge; `o_ldSig` low next cycle. Partial SWAP after WR_A leaves dst updated, src not; no `o_done`.
- Cycles from acceptance edge to `o_done` high: LOAD_IMM 2, MOVE 3, READ 2, SWAP 5. Next command accepted earliest the cycle after FIN.
- Register write lands at the edge ending the WR state; a READ of that register issued next returns the new value.

## Configuration
- `REG_SWAP_EN` defined: opcode 11 executes SWAP as above.
- Undefined: opcode 11 is illegal; accepted, IDLE → FIN with no register access (`o_ldSig` never asserted), `o_done` and `o_cmdErr` pulse 2 cycles after acceptance. RD_B/WR_B and tmpB removed.

## Test plan
- Reset, then LOAD_IMM dst=0 imm=10 → one `o_ldSig` cycle with sel=0, data=10; `o_done` 2 cycles after accept; `o_cmdErr`=0.
- LOAD_IMM r3=20, then READ src=3 → `o_rspValid` pulse with `o_rspData`=20, 2 cycles after accept.
- LOAD_IMM r1=0x5A, MOVE dst=7 src=1, READ r7 → 0x5A; READ r1 → 0x5A.
- With `REG_SWAP_EN`: r2=0x11, r4=0x22, SWAP dst=2 src=4 → `o_done` at 5 cycles; READ r2=0x22, r4=0x11. Without: `o_cmdErr` pulse, r2/r4 unchanged, no `o_ldSig`.
- `i_cmdValid` held high with changing fields during MOVE → fields ignored; `o_cmdReady`=0 until IDLE; back-to-back commands complete in order.
- Assert `i_rst` during SWAP WR_B (or MOVE RD_A) → no `o_done`; outputs 0 next cycle; `o_cmdReady`=1 after reset released; subsequent LOAD_IMM works.

Source files
------------

// File: rtl/reg_access_sequencer.sv
// rtl/reg_access_sequencer.sv - register file command sequencer (optional SWAP via REG_SWAP_EN)
module reg_access_sequencer #(
  parameter int SELECT_WIDTH = 4,
  parameter int REG_WIDTH    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmdValid,
  output logic                    o_cmdReady,
  input  logic [1:0]              i_cmdOp,
  input  logic [SELECT_WIDTH-1:0] i_cmdDst,
  input  logic [SELECT_WIDTH-1:0] i_cmdSrc,
  input  logic [REG_WIDTH-1:0]    i_cmdImm,
  output logic                    o_ldSig,
  output logic [SELECT_WIDTH-1:0] o_regSel,
  output logic [REG_WIDTH-1:0]    o_regData,
  input  logic [REG_WIDTH-1:0]    i_regData,
  output logic                    o_rspValid,
  output logic [REG_WIDTH-1:0]    o_rspData,
  output logic                    o_done,
  output logic                    o_cmdErr
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, FIN} state_t;

  state_t state, nextState;

  logic [1:0]              opReg;
  logic [SELECT_WIDTH-1:0] dstReg, srcReg;
  logic [REG_WIDTH-1:0]    immReg;

  // MOVE and READ forward the read value straight into o_regData/o_rspData at
  // the edge ending RD_A, so holding registers are only needed for SWAP.
`ifdef REG_SWAP_EN
  logic [REG_WIDTH-1:0]    tmpA, tmpB;
`endif

  // Effective command fields: live inputs while idle, latched copy afterwards.
  logic [1:0]              opN;
  logic [SELECT_WIDTH-1:0] dstN, srcN;
  logic [REG_WIDTH-1:0]    immN;
  logic                    illegalN;

  // Registered-output precursors, derived from the state being entered.
  logic                    nextLd, nextReady, nextDone, nextRsp, nextErr;
  logic [SELECT_WIDTH-1:0] nextSel;
  logic [REG_WIDTH-1:0]    nextData;

  // Select command fields and decide whether the opcode is executable.
  always_comb begin
    opN  = (state == IDLE) ? i_cmdOp  : opReg;
    dstN = (state == IDLE) ? i_cmdDst : dstReg;
    srcN = (state == IDLE) ? i_cmdSrc : srcReg;
    immN = (state == IDLE) ? i_cmdImm : immReg;
`ifdef REG_SWAP_EN
    illegalN = 1'b0;
`else
    illegalN = (opN == OP_SWAP);
`endif
  end

  // Next-state logic; an illegal opcode idles one cycle in RD_A with no select
  // so its done/err pulse lands at the same offset as LOAD_IMM and READ.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (i_cmdValid) begin
          nextState = (opN == OP_LOAD) ? WR_A : RD_A;
        end
      end
      RD_A: begin
        if (opN == OP_MOVE) begin
          nextState = WR_A;
`ifdef REG_SWAP_EN
        end else if (opN == OP_SWAP) begin
          nextState = RD_B;
`endif
        end else begin
          nextState = FIN;
        end
      end
      RD_B: nextState = WR_A;
      WR_A: begin
`ifdef REG_SWAP_EN
        nextState = (opN == OP_SWAP) ? WR_B : FIN;
`else
        nextState = FIN;
`endif
      end
      WR_B:    nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output values for the state being entered; registered below.
  always_comb begin
    nextLd    = 1'b0;
    nextReady = 1'b0;
    nextDone  = 1'b0;
    nextRsp   = 1'b0;
    nextErr   = 1'b0;
    nextSel   = '0;
    nextData  = '0;
    case (nextState)
      IDLE: nextReady = 1'b1;
      RD_A: nextSel = illegalN ? '0 : srcN;
      RD_B: nextSel = dstN;
      WR_A: begin
        nextLd  = 1'b1;
        nextSel = dstN;
        if (opN == OP_LOAD) begin
          nextData = immN;
`ifdef REG_SWAP_EN
        end else if (opN == OP_SWAP) begin
          nextData = tmpA;
`endif
        end else begin
          nextData = i_regData;
        end
      end
      WR_B: begin
        nextLd  = 1'b1;
        nextSel = srcN;
`ifdef REG_SWAP_EN
        nextData = tmpB;
`endif
      end
      FIN: begin
        nextDone = 1'b1;
        nextRsp  = (opN == OP_READ);
        nextErr  = illegalN;
      end
      default: nextReady = 1'b0;
    endcase
  end

  // State, latched command, holding registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      opReg      <= '0;
      dstReg     <= '0;
      srcReg     <= '0;
      immReg     <= '0;
      o_cmdReady <= 1'b1;
      o_ldSig    <= 1'b0;
      o_regSel   <= '0;
      o_regData  <= '0;
      o_rspValid <= 1'b0;
      o_rspData  <= '0;
      o_done     <= 1'b0;
      o_cmdErr   <= 1'b0;
`ifdef REG_SWAP_EN
      tmpA       <= '0;
      tmpB       <= '0;
`endif
    end else begin
      state      <= nextState;
      o_cmdReady <= nextReady;
      o_ldSig    <= nextLd;
      o_regSel   <= nextSel;
      o_regData  <= nextData;
      o_rspValid <= nextRsp;
      o_done     <= nextDone;
      o_cmdErr   <= nextErr;
      if (state == IDLE && i_cmdValid) begin
        opReg  <= i_cmdOp;
        dstReg <= i_cmdDst;
        srcReg <= i_cmdSrc;
        immReg <= i_cmdImm;
      end
      if (state == RD_A && opReg == OP_READ) begin
        o_rspData <= i_regData;
      end
`ifdef REG_SWAP_EN
      if (state == RD_A) begin
        tmpA <= i_regData;
      end
      if (state == RD_B) begin
        tmpB <= i_regData;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_access_sequencer.sv
// tb/tb_reg_access_sequencer.sv - scoreboard bench for reg_access_sequencer
module tb_reg_access_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmdOp;
  logic [3:0] cmdDst, cmdSrc;
  logic [7:0] cmdImm;
  logic       ldSig;
  logic [3:0] regSel;
  logic [7:0] regDataOut, regDataIn;
  logic       rspValid;
  logic [7:0] rspData;
  logic       done;
  logic       cmdErr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         accCyc;
    int         lat;
    bit         isRead;
    logic [7:0] data;
    bit         err;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] data;
  } wr_t;

  exp_t       expQ[$];
  wr_t        wrQ[$];
  logic [7:0] refRegs[16];
  logic [7:0] rf[16];

  reg_access_sequencer #(.SELECT_WIDTH(4), .REG_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmdValid(cmdValid), .o_cmdReady(cmdReady),
    .i_cmdOp(cmdOp), .i_cmdDst(cmdDst), .i_cmdSrc(cmdSrc), .i_cmdImm(cmdImm),
    .o_ldSig(ldSig), .o_regSel(regSel), .o_regData(regDataOut), .i_regData(regDataIn),
    .o_rspValid(rspValid), .o_rspData(rspData), .o_done(done), .o_cmdErr(cmdErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file the sequencer drives; cleared only during power-on reset.
  always @(posedge clk) begin
    if (rst && cyc < 4) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (ldSig) begin
      rf[regSel] <= regDataOut;
    end
  end
  assign regDataIn = rf[regSel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops expected writes and completions as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (ldSig) begin
        if (wrQ.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t w;
          w = wrQ.pop_front();
          check("wr_sel", regSel, w.sel);
          check("wr_data", regDataOut, w.data);
        end
      end
      if (done) begin
        if (expQ.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("done_latency", cyc - e.accCyc, e.lat);
          check("cmd_err", cmdErr, e.err);
          check("rsp_valid", rspValid, e.isRead);
          if (e.isRead) check("rsp_data", rspData, e.data);
        end
      end else if (rspValid || cmdErr) begin
        check("stray_pulse", {rspValid, cmdErr}, 0);
      end
    end
  end

  task automatic waitReady(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!cmdReady && n < 100) begin
      cmdValid = 1'($urandom);
      cmdOp    = 2'($urandom);
      cmdDst   = 4'($urandom);
      cmdSrc   = 4'($urandom);
      cmdImm   = 8'($urandom);
      @(negedge clk);
      n++;
    end
    ok = cmdReady;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  // Drive one command and record its expected effect from the register rules.
  task automatic issue(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                       input logic [7:0] imm);
    bit   ok;
    exp_t e;
    logic [7:0] a, b;
    waitReady(ok);
    if (!ok) return;
    cmdValid = 1'b1;
    cmdOp = op; cmdDst = dst; cmdSrc = src; cmdImm = imm;
    e.accCyc = cyc; e.isRead = 0; e.data = 8'h00; e.err = 0; e.lat = 2;
    a = refRegs[src];
    b = refRegs[dst];
    case (op)
      2'b00: begin
        wrQ.push_back('{dst, imm});
        refRegs[dst] = imm;
      end
      2'b01: begin
        e.lat = 3;
        wrQ.push_back('{dst, a});
        refRegs[dst] = a;
      end
      2'b10: begin
        e.isRead = 1;
        e.data = a;
      end
      default: begin
`ifdef REG_SWAP_EN
        e.lat = 5;
        wrQ.push_back('{dst, a});
        wrQ.push_back('{src, b});
        refRegs[dst] = a;
        refRegs[src] = b;
`else
        e.err = 1;
`endif
      end
    endcase
    expQ.push_back(e);
  endtask

  initial begin
    bit ok;
    int n;
    for (int i = 0; i < 16; i++) refRegs[i] = 8'h00;
    rst = 1'b1; cmdValid = 1'b0; cmdOp = 2'b00; cmdDst = 4'h0; cmdSrc = 4'h0; cmdImm = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", cmdReady, 1);
    check("rst_outputs", {ldSig, done, rspValid, cmdErr}, 0);
    check("rst_sel_data", {regSel, regDataOut}, 0);
    check("rst_rsp_data", rspData, 0);
    rst = 1'b0;

    issue(2'b00, 4'd0, 4'd0, 8'd10);
    issue(2'b00, 4'd3, 4'd0, 8'd20);
    issue(2'b10, 4'd0, 4'd3, 8'd0);
    issue(2'b00, 4'd1, 4'd0, 8'h5A);
    issue(2'b01, 4'd7, 4'd1, 8'hFF);
    issue(2'b10, 4'd0, 4'd7, 8'd0);
    issue(2'b10, 4'd0, 4'd1, 8'd0);
    issue(2'b00, 4'd2, 4'd0, 8'h11);
    issue(2'b00, 4'd4, 4'd0, 8'h22);
    issue(2'b11, 4'd2, 4'd4, 8'd0);
    issue(2'b10, 4'd0, 4'd2, 8'd0);
    issue(2'b10, 4'd0, 4'd4, 8'd0);
    issue(2'b01, 4'd5, 4'd5, 8'd0);
    issue(2'b11, 4'd6, 4'd6, 8'd0);
    issue(2'b10, 4'd0, 4'd5, 8'd0);

    // Abort a MOVE in RD_A: no write, no done, outputs cleared at once.
    waitReady(ok);
    if (ok) begin
      cmdValid = 1'b1; cmdOp = 2'b01; cmdDst = 4'd9; cmdSrc = 4'd1; cmdImm = 8'h00;
      @(negedge clk);
      rst = 1'b1; cmdValid = 1'b0;
      @(negedge clk);
      check("abort_ldsig", ldSig, 0);
      check("abort_ready", cmdReady, 1);
      check("abort_outputs", {done, rspValid, cmdErr, regSel, regDataOut}, 0);
      rst = 1'b0;
    end
    issue(2'b00, 4'd9, 4'd0, 8'hC3);
    issue(2'b10, 4'd0, 4'd9, 8'd0);

    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) issue(2'b10, 4'd0, 4'(i), 8'd0);

    @(negedge clk);
    cmdValid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", expQ.size(), 0);
    check("drain_writes", wrQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
